// File: rtl/pwm_fade_sequencer.sv
// Brightness fade sequencer: ramps the PWM compare value toward a per-level target, updating only on period boundaries.
// Optional breathe mode is compiled in when PWM_FADE_BREATHE_EN is defined.
`timescale 1ns/1ps
module pwm_fade_sequencer #(
  parameter int PERIOD_TICKS = 50000,
  parameter int DUTY_W       = 16,
  parameter int STEP         = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_pulse,
  input  logic              down_pulse,
  input  logic              mode_toggle,
  input  logic              period_end,
  output logic [3:0]        level,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_load,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
`ifdef PWM_FADE_BREATHE_EN
    ,
    BREATHE_UP,
    BREATHE_DOWN
`endif
  } state_t;

  // Wide intermediate so PERIOD_TICKS*(k+1) cannot overflow before the divide.
  function automatic logic [DUTY_W-1:0] calc_target(input int unsigned k);
    logic [63:0] prod;
    prod = 64'(PERIOD_TICKS) * 64'(k + 1);
    return DUTY_W'(prod / 64'd10);
  endfunction

  localparam logic [DUTY_W-1:0] DUTY_RST = calc_target(4);
  localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W+1)'(STEP);

  // One step toward tgt, clamped so it never overshoots, wraps or underflows.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W:0] up_sum;
    logic [DUTY_W:0] gap;
    up_sum = {1'b0, cur} + STEP_X;
    gap    = (cur > tgt) ? {1'b0, cur - tgt} : '0;
    if (cur < tgt)
      return (up_sum >= {1'b0, tgt}) ? tgt : up_sum[DUTY_W-1:0];
    else if (gap > STEP_X)
      return cur - STEP_X[DUTY_W-1:0];
    else
      return tgt;
  endfunction

  function automatic logic [3:0] next_level(input logic [3:0] cur,
                                            input logic up,
                                            input logic dn);
    if (up && !dn && cur < 4'd8) return cur + 4'd1;
    if (dn && !up && cur != 4'd0) return cur - 4'd1;
    return cur;
  endfunction

  logic [DUTY_W-1:0] target_tbl [0:8];
  for (genvar k = 0; k < 9; k++) begin : g_tgt
    assign target_tbl[k] = calc_target(k);
  end

  state_t            state, state_nx;
  logic [DUTY_W-1:0] tgt_sel, stepped, duty_nx;
  logic [3:0]        level_nx;
  logic              load_nx, in_breathe;

`ifndef PWM_FADE_BREATHE_EN
  logic unused_mode_toggle;
  assign unused_mode_toggle = mode_toggle;
`endif

  // State register: every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      level     <= 4'd4;
      duty      <= DUTY_RST;
      duty_load <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      level     <= level_nx;
      duty      <= duty_nx;
      duty_load <= load_nx;
      busy      <= (state_nx != IDLE);
    end
  end

  // Next-state logic: direction choice and completion are decided on the same edge as the step.
  always_comb begin
    state_nx = state;
    case (state)
`ifdef PWM_FADE_BREATHE_EN
      BREATHE_UP: begin
        if (period_end && stepped == tgt_sel) state_nx = BREATHE_DOWN;
        if (mode_toggle) state_nx = IDLE;
      end
      BREATHE_DOWN: begin
        if (period_end && stepped == tgt_sel) state_nx = BREATHE_UP;
        if (mode_toggle) state_nx = IDLE;
      end
`endif
      default: begin
        if (period_end) begin
          if (stepped == tgt_sel)   state_nx = IDLE;
          else if (duty < tgt_sel)  state_nx = RAMP_UP;
          else                      state_nx = RAMP_DOWN;
        end
`ifdef PWM_FADE_BREATHE_EN
        if (mode_toggle) state_nx = BREATHE_UP;
`endif
      end
    endcase
  end

  // Output logic: the step always follows the state held before the edge.
  always_comb begin
    tgt_sel    = target_tbl[level];
    in_breathe = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
    case (state)
      BREATHE_UP:   begin tgt_sel = target_tbl[8]; in_breathe = 1'b1; end
      BREATHE_DOWN: begin tgt_sel = target_tbl[0]; in_breathe = 1'b1; end
      default:      ;
    endcase
`endif
    stepped  = step_toward(duty, tgt_sel);
    duty_nx  = period_end ? stepped : duty;
    load_nx  = period_end && (stepped != duty);
    level_nx = in_breathe ? level : next_level(level, up_pulse, down_pulse);
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer: a spec-level model queues expected duty loads, a monitor checks them.
`timescale 1ns/1ps
module tb_pwm_fade_sequencer;
  localparam int PT = 1000;
  localparam int DW = 16;
  localparam int ST = 25;
`ifdef PWM_FADE_BREATHE_EN
  localparam bit BREATHE_ON = 1'b1;
`else
  localparam bit BREATHE_ON = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic up_pulse = 1'b0, down_pulse = 1'b0, mode_toggle = 1'b0, period_end = 1'b0;
  logic [3:0]    level;
  logic [DW-1:0] duty;
  logic          duty_load, busy;

  int total = 0, bad = 0;

  typedef struct {
    int duty;
    int level;
    int busy;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int m_level, m_duty;
  bit m_busy, m_breathe, m_bup, m_load;

  pwm_fade_sequencer #(.PERIOD_TICKS(PT), .DUTY_W(DW), .STEP(ST)) dut (
    .clk(clk), .rst(rst), .up_pulse(up_pulse), .down_pulse(down_pulse),
    .mode_toggle(mode_toggle), .period_end(period_end),
    .level(level), .duty(duty), .duty_load(duty_load), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int tgt(int k);
    return (PT * (k + 1)) / 10;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 4; m_duty = tgt(4); m_busy = 0; m_breathe = 0; m_bup = 0; m_load = 0;
  endtask

  // Behavioural reference: one clock edge with the given sampled inputs.
  task automatic model_edge(bit u, bit d, bit t, bit p);
    int tg, nd;
    m_load = 0;
    tg = m_breathe ? (m_bup ? tgt(8) : tgt(0)) : tgt(m_level);
    if (p) begin
      if (m_duty < tg) nd = (m_duty + ST > tg) ? tg : m_duty + ST;
      else             nd = (m_duty - ST < tg) ? tg : m_duty - ST;
      if (m_breathe) begin
        if (nd == tg) m_bup = !m_bup;
      end else begin
        m_busy = (nd != tg);
      end
      m_load = (nd != m_duty);
      m_duty = nd;
    end
    if (!m_breathe) begin
      if (u && !d && m_level < 8) m_level++;
      if (d && !u && m_level > 0) m_level--;
    end
    if (t && BREATHE_ON) begin
      if (m_breathe) begin m_breathe = 0; m_busy = 0; end
      else begin m_breathe = 1; m_bup = 1; m_busy = 1; end
    end
    if (m_load) sbq.push_back('{m_duty, m_level, int'(m_busy)});
  endtask

  task automatic tick(bit u, bit d, bit t, bit p);
    @(negedge clk);
    up_pulse = u; down_pulse = d; mode_toggle = t; period_end = p;
    @(posedge clk);
    model_edge(u, d, t, p);
  endtask

  task automatic pe_run(int n);
    for (int i = 0; i < n; i++) begin
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 0);
    end
  endtask

  task automatic check_model(string tag);
    #2;
    chk({tag, "_level"}, level, m_level);
    chk({tag, "_duty"}, duty, m_duty);
    chk({tag, "_busy"}, busy, m_busy);
    chk({tag, "_load"}, duty_load, m_load);
  endtask

  // Monitor: every expected load must appear on the cycle after its period_end, and no other.
  always @(negedge clk) begin
    if (!rst) begin
      if (duty_load) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected_load: got duty=%0d want no load", duty);
        end else begin
          mon_e = sbq.pop_front();
          chk("sb_duty", duty, mon_e.duty);
          chk("sb_level", level, mon_e.level);
          chk("sb_busy", busy, mon_e.busy);
        end
      end else if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        total++; bad++;
        $display("FAIL sb_missing_load: got no load want duty=%0d", mon_e.duty);
      end
    end
  end

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_level", level, 4);
    chk("rst_duty", duty, 500);
    chk("rst_load", duty_load, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); #1 rst = 1'b0;

    tick(1, 0, 0, 0);
    check_model("single_up");
    pe_run(4);
    #2;
    chk("single_up_level", level, 5);
    chk("single_up_duty", duty, 600);
    chk("single_up_busy", busy, 0);

    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0);
    pe_run(20);
    #2;
    chk("sat_hi_level", level, 8);
    chk("sat_hi_duty", duty, 900);
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
    pe_run(36);
    #2;
    chk("sat_lo_level", level, 0);
    chk("sat_lo_duty", duty, 100);
    chk("sat_lo_busy", busy, 0);

    tick(1, 1, 0, 0);
    pe_run(2);
    #2;
    chk("simul_level", level, 0);
    chk("simul_duty", duty, 100);

    @(negedge clk); #1 rst = 1'b1;
    model_reset(); sbq.delete();
    @(negedge clk); #1 rst = 1'b0;
    tick(1, 0, 0, 0);
    pe_run(2);
    #2;
    chk("midramp_duty_before", duty, 550);
    chk("midramp_busy_before", busy, 1);
    @(negedge clk);
    up_pulse = 0; down_pulse = 0; mode_toggle = 0; period_end = 0;
    #1 rst = 1'b1;
    #1;
    chk("midramp_rst_duty", duty, 500);
    chk("midramp_rst_level", level, 4);
    chk("midramp_rst_busy", busy, 0);
    chk("midramp_rst_load", duty_load, 0);
    model_reset(); sbq.delete();
    @(negedge clk); #1 rst = 1'b0;

    tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    check_model("toggle");
    pe_run(16);
    #2;
    if (BREATHE_ON) begin
      chk("breathe_peak_duty", duty, 900);
      chk("breathe_level_frozen", level, 4);
      pe_run(8);
      #2;
      chk("breathe_down_duty", duty, 700);
      tick(0, 0, 1, 0);
      pe_run(8);
      #2;
      chk("breathe_exit_duty", duty, 500);
      chk("breathe_exit_busy", busy, 0);
    end else begin
      chk("no_breathe_duty", duty, 600);
      chk("no_breathe_level", level, 5);
      chk("no_breathe_busy", busy, 0);
    end

    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0);
      if (i % 100 == 99) check_model("rand");
    end

    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    #2;
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
# pwm_fade_sequencer

Sequencing controller for the PWM brightness datapath. Takes debounced single-cycle up/down brightness events and an optional breathe-mode request. Ramps the PWM compare value toward the selected level in fixed steps, and updates it only at PWM period boundaries so the output waveform never glitches. Sits between the button debounce/edge-detect logic and the PWM counter/comparator, which consumes `duty` whenever `duty_load` pulses.

## Interface
- `PERIOD_TICKS`, default 50000: clk cycles per PWM period; the downstream counter runs 0..PERIOD_TICKS-1.
- `DUTY_W`, default 16: width of `duty`; PERIOD_TICKS must fit in DUTY_W bits.
- `STEP`, default 500: duty increment/decrement applied per PWM period while ramping; must be ≥1.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `up_pulse` in 1: one-cycle request to raise the brightness level.
- `down_pulse` in 1: one-cycle request to lower the brightness level.
- `mode_toggle` in 1: one-cycle request to toggle breathe mode.
- `period_end` in 1: one-cycle strobe from the PWM counter on its last count (PERIOD_TICKS-1).
- `level` out 4: current brightness level, 0..8.
- `duty` out DUTY_W: compare value for the PWM generator.
- `duty_load` out 1: one-cycle strobe; `duty` changed on this cycle.
- `busy` out 1: high while the FSM is not in IDLE.

## Operation
- **Targets:** target(k) = (PERIOD_TICKS*(k+1))/10, truncated, for k = 0..8 (10%..90%). They are computed at elaboration and use ≥32-bit intermediates.
- **Level:**
  - `up_pulse` increments `level`, saturating at 8.
  - `down_pulse` decrements `level`, saturating at 0.
  - Both pulses in the same cycle: no change.
  - Level updates at the clock edge that samples the pulse, in any FSM state except BREATHE.
- **FSM states:** IDLE, RAMP_UP, RAMP_DOWN, BREATHE_UP, BREATHE_DOWN.
- **Direction selection:** evaluated on every `period_end` in IDLE/RAMP_*:
  - `duty` < target(level) → RAMP_UP.
  - `duty` > target(level) → RAMP_DOWN.
  - Equal → IDLE.
- **RAMP_UP step:** on `period_end`, `duty` <= min(`duty`+STEP, target). Computed in DUTY_W+1 bits with no wrap.
- **RAMP_DOWN step:** on `period_end`, `duty` <= max(`duty`-STEP, target). Underflow is clamped by comparing before subtracting.
- **Ramp completion:** when `duty` reaches target, state returns to IDLE at the same edge.
- **Level change mid-ramp:** direction is re-evaluated at the next `period_end`. The step at an edge uses the target registered before that edge.
- **BREATHE entry:** `mode_toggle` from IDLE/RAMP_* enters BREATHE_UP.
  - Up/down pulses are ignored and `level` is frozen.
- **BREATHE_UP:** steps toward target(8). On reaching it, the state becomes BREATHE_DOWN at the same edge.
- **BREATHE_DOWN:** steps toward target(0). On reaching it, the state becomes BREATHE_UP at the same edge.
- **BREATHE exit:** `mode_toggle` in BREATHE_* exits to IDLE. The normal ramp back to target(level) begins at the next `period_end`.
- **Toggle coincidence:** `mode_toggle` coinciding with `period_end` takes effect on the state; the duty step of that edge still follows the old state.
- **Reset values:**
  - `level`=4, `duty`=target(4), `duty_load`=0, `busy`=0, state IDLE, breathe off.

## Timing
- All outputs are registered.
- `duty` and `duty_load` change at the edge that samples `period_end`=1. `duty_load` is high for exactly that one following cycle, and only when `duty` actually changed.
- The downstream counter restarts at 0 in the same cycle, so the new duty applies to the full next period.
- Latency from a level pulse to the first `duty` change: up to one PWM period (next `period_end`).
- `busy` goes high at the edge that registers the direction choice and goes low at the edge the final step lands.
- `rst` asserted mid-ramp: all outputs take reset values immediately, without waiting for a clock edge. Release is synchronous to the next edge.

## Configuration
- `PWM_FADE_BREATHE_EN` defined: BREATHE_UP/BREATHE_DOWN states and `mode_toggle` handling are compiled in.
- Undefined: those states are absent, `mode_toggle` is ignored (port kept, unused), and the FSM is IDLE/RAMP_UP/RAMP_DOWN only.

## Test plan
All scenarios use PERIOD_TICKS=1000, STEP=25; targets are 100..900.
- **Reset:** assert `rst` without clock → `level`=4, `duty`=500, `duty_load`=0, `busy`=0.
- **Single up:** one `up_pulse`, then 4 `period_end` strobes → `level`=5; `duty` = 525, 550, 575, 600, each with one `duty_load` cycle; `busy` drops after 600.
- **Saturation:** 6 `up_pulse` → `level`=8, `duty` settles at 900 after 16 periods. Same for `down_pulse` bottoming at `level`=0, `duty`=100.
- **Simultaneous:** `up_pulse` and `down_pulse` in the same cycle → `level` unchanged, no `duty_load`.
- **Breathe (macro on):** `mode_toggle` from reset → 16 periods up to 900, then down to 100, repeating. Second toggle at `duty`=700 → ramps down to 500 in 8 periods. With the macro off, `mode_toggle` has no effect.
- **Reset mid-ramp:** `rst` asserted at `duty`=550 → immediately `duty`=500, `level`=4, `busy`=0.
